pe_ws_db: RTL and testbench

//  Weight-stationary systolic processing element with a double-buffered weight register.
//  The next weight shifts into a shadow register while the current weight keeps computing.

---
 rtl/pe_ws_db.sv | 152 +++++++++++++++
 tb/tb_pe_ws_db.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ws_db.sv
// pe_ws_db: weight-stationary systolic processing element with a double-buffered weight.
//   The next weight shifts into a shadow register while the active weight keeps computing.
//   Activations flow east, partial sums flow south, and weights shift south through the shadow chain.
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   en_i                        global stall (0 = every register holds)
//   data_i/data_valid_i         activation from the west and its qualifier
//   acc_i                       partial sum from the north
//   weight_i, wload_i, wswap_i  weight shift-chain input, shadow load, and shadow->active swap
//   clr_i                       clears the counters and the sticky overflow flag
//   data_o/data_valid_o         registered activation to the east
//   acc_o/acc_valid_o           registered partial sum to the south
//   weight_o                    shadow register (shift-chain output)
//   ovf_o                       sticky overflow flag
//   mac_cnt_o, skip_cnt_o       saturating performance counters
module pe_ws_db #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter bit SATURATE     = 1'b1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    data_valid_i,
  input  logic [ACC_WIDTH-1:0]    acc_i,
  input  logic [WEIGHT_WIDTH-1:0] weight_i,
  input  logic                    wload_i,
  input  logic                    wswap_i,
  input  logic                    clr_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    data_valid_o,
  output logic [ACC_WIDTH-1:0]    acc_o,
  output logic                    acc_valid_o,
  output logic [WEIGHT_WIDTH-1:0] weight_o,
  output logic                    ovf_o,
  output logic [CNT_WIDTH-1:0]    mac_cnt_o,
  output logic [CNT_WIDTH-1:0]    skip_cnt_o
);
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    dvld_q, dvld_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    accv_q, accv_d;
  logic [WEIGHT_WIDTH-1:0] shadow_q, shadow_d;
  logic                    sfull_q, sfull_d;
  logic [WEIGHT_WIDTH-1:0] wact_q, wact_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]    mac_q, mac_d;
  logic [CNT_WIDTH-1:0]    skip_q, skip_d;

  // Both operands are sign-extended to the full product width so the PW-bit
  // product is exact without relying on context-width rules.
  logic signed [PW-1:0]    d_x, w_x, prod;
  logic signed [ACC_WIDTH:0] sum;
  logic                    zero_op, do_mac, ovf_now;

  assign d_x  = {{WEIGHT_WIDTH{data_i[DATA_WIDTH-1]}}, data_i};
  assign w_x  = {{DATA_WIDTH{wact_q[WEIGHT_WIDTH-1]}}, wact_q};
  assign prod = d_x * w_x;
  // One guard bit above ACC_WIDTH: overflow shows up as the top two bits differing.
  assign sum  = {acc_i[ACC_WIDTH-1], acc_i} + {{(ACC_WIDTH+1-PW){prod[PW-1]}}, prod};

  assign zero_op = (data_i == '0) || (wact_q == '0);
  assign do_mac  = data_valid_i && !zero_op;
  assign ovf_now = do_mac && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);

  // Datapath next state; invalid or zero-skipped beats pass acc_i straight through.
  always_comb begin
    data_d = data_i;
    dvld_d = data_valid_i;
    accv_d = data_valid_i;
    acc_d  = acc_i;
    if (do_mac) begin
      if (ovf_now && SATURATE) acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else                     acc_d = sum[ACC_WIDTH-1:0];
    end
  end

  // Counters and sticky overflow; clear wins over a same-cycle increment.
  always_comb begin
    mac_d  = mac_q;
    skip_d = skip_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      mac_d  = '0;
      skip_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (do_mac && (mac_q != '1))                           mac_d  = mac_q + CNT_ONE;
      if (data_valid_i && zero_op && (skip_q != '1))         skip_d = skip_q + CNT_ONE;
      if (ovf_now)                                           ovf_d  = 1'b1;
    end
  end

  // Weight double buffer. A swap reads the old shadow, so load+swap in one cycle
  // moves the old shadow into w_act while weight_i refills the shadow.
  always_comb begin
    shadow_d = shadow_q;
    sfull_d  = sfull_q;
    wact_d   = wact_q;
    if (wswap_i && sfull_q) begin
      wact_d  = shadow_q;
      sfull_d = 1'b0;
    end
    if (wload_i) begin
      shadow_d = weight_i;
      sfull_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      dvld_q   <= 1'b0;
      acc_q    <= '0;
      accv_q   <= 1'b0;
      shadow_q <= '0;
      sfull_q  <= 1'b0;
      wact_q   <= '0;
      ovf_q    <= 1'b0;
      mac_q    <= '0;
      skip_q   <= '0;
    end else if (en_i) begin
      data_q   <= data_d;
      dvld_q   <= dvld_d;
      acc_q    <= acc_d;
      accv_q   <= accv_d;
      shadow_q <= shadow_d;
      sfull_q  <= sfull_d;
      wact_q   <= wact_d;
      ovf_q    <= ovf_d;
      mac_q    <= mac_d;
      skip_q   <= skip_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dvld_q;
  assign acc_o        = acc_q;
  assign acc_valid_o  = accv_q;
  assign weight_o     = shadow_q;
  assign ovf_o        = ovf_q;
  assign mac_cnt_o    = mac_q;
  assign skip_cnt_o   = skip_q;
endmodule

// File: tb/tb_pe_ws_db.sv
// tb_pe_ws_db: scoreboard bench for pe_ws_db. Two instances (saturating and wrapping,
// 16-bit accumulator, 4-bit counters) share one stimulus stream. The driver updates an
// arithmetic reference model and queues the expected outputs; the monitor pops and
// compares after every clock edge.
module tb_pe_ws_db;
  localparam int AW = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0, dv = 1'b0, wl = 1'b0, ws = 1'b0, clr = 1'b0;
  logic [7:0]    din = '0, win = '0;
  logic [AW-1:0] ain = '0;

  logic [7:0]    s_data, w_data, s_wo, w_wo;
  logic          s_dv, w_dv, s_accv, w_accv, s_ovf, w_ovf;
  logic [AW-1:0] s_acc, w_acc;
  logic [CW-1:0] s_mac, w_mac, s_skip, w_skip;

  pe_ws_db #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(AW), .SATURATE(1'b1), .CNT_WIDTH(CW)) u_sat (
    .clk(clk), .rst(rst), .en_i(en), .data_i(din), .data_valid_i(dv), .acc_i(ain),
    .weight_i(win), .wload_i(wl), .wswap_i(ws), .clr_i(clr),
    .data_o(s_data), .data_valid_o(s_dv), .acc_o(s_acc), .acc_valid_o(s_accv),
    .weight_o(s_wo), .ovf_o(s_ovf), .mac_cnt_o(s_mac), .skip_cnt_o(s_skip));

  pe_ws_db #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(AW), .SATURATE(1'b0), .CNT_WIDTH(CW)) u_wrap (
    .clk(clk), .rst(rst), .en_i(en), .data_i(din), .data_valid_i(dv), .acc_i(ain),
    .weight_i(win), .wload_i(wl), .wswap_i(ws), .clr_i(clr),
    .data_o(w_data), .data_valid_o(w_dv), .acc_o(w_acc), .acc_valid_o(w_accv),
    .weight_o(w_wo), .ovf_o(w_ovf), .mac_cnt_o(w_mac), .skip_cnt_o(w_skip));

  typedef struct {
    logic [7:0]    data;
    logic          dv, accv, ovf;
    logic [AW-1:0] acc_s, acc_w;
    logic [7:0]    wo;
    int            mac, skip;
    bit            sp_on, sp_cnt;
    logic [AW-1:0] sp_acc, sp_accw;
    logic          sp_accv, sp_ovf;
    int            sp_mac, sp_skip;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0;

  // Reference model state (plain integers, behavioural).
  logic [7:0]    m_data, m_shadow, m_wact;
  logic          m_dv, m_accv, m_full, m_ovf;
  logic [AW-1:0] m_acc_s, m_acc_w;
  int            m_mac, m_skip;

  // Hand-derived expectations attached to the next step.
  bit sp_on = 0, sp_cnt = 0;
  logic [AW-1:0] sp_acc, sp_accw;
  logic sp_accv, sp_ovf;
  int sp_mac, sp_skip;

  task automatic spec(input int a_sat, input int a_wrap, input logic v, input logic o);
    sp_on = 1; sp_acc = AW'(a_sat); sp_accw = AW'(a_wrap); sp_accv = v; sp_ovf = o;
  endtask

  task automatic spec_cnt(input int mac, input int skip);
    sp_cnt = 1; sp_mac = mac; sp_skip = skip;
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] d, input bit v,
                      input logic [AW-1:0] a, input logic [7:0] wi, input bit l,
                      input bit sw, input bit c);
    exp_t x;
    longint s;
    bit of;
    @(negedge clk);
    rst = r; en = e; din = d; dv = v; ain = a; win = wi; wl = l; ws = sw; clr = c;
    if (r) begin
      m_data = '0; m_shadow = '0; m_wact = '0; m_dv = 0; m_accv = 0; m_full = 0;
      m_ovf = 0; m_acc_s = '0; m_acc_w = '0; m_mac = 0; m_skip = 0;
    end else if (e) begin
      s = longint'($signed(a));
      if (v) begin
        if (d == 0 || m_wact == 0) begin
          if (m_skip < CMAX) m_skip++;
        end else begin
          s = s + longint'($signed(d)) * longint'($signed(m_wact));
          if (m_mac < CMAX) m_mac++;
        end
      end
      of = (s > 32767) || (s < -32768);
      m_acc_s = of ? ((s > 0) ? 16'h7fff : 16'h8000) : AW'(s);
      m_acc_w = AW'(s);
      m_data = d; m_dv = v; m_accv = v;
      if (c) begin
        m_mac = 0; m_skip = 0; m_ovf = 0;
      end else if (of) m_ovf = 1;
      if (sw && m_full) begin m_wact = m_shadow; m_full = 0; end
      if (l) begin m_shadow = wi; m_full = 1; end
    end
    x.data = m_data; x.dv = m_dv; x.accv = m_accv; x.ovf = m_ovf;
    x.acc_s = m_acc_s; x.acc_w = m_acc_w; x.wo = m_shadow; x.mac = m_mac; x.skip = m_skip;
    x.sp_on = sp_on; x.sp_cnt = sp_cnt; x.sp_acc = sp_acc; x.sp_accw = sp_accw;
    x.sp_accv = sp_accv; x.sp_ovf = sp_ovf; x.sp_mac = sp_mac; x.sp_skip = sp_skip;
    sp_on = 0; sp_cnt = 0;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL cyc %0d %s: got %0h expected %0h", cyc, n, act, ex);
    end
  endtask

  // Monitor: the DUT presents a full output set after every edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_o",       32'(s_data),  32'(e.data));
      chk("data_valid_o", 32'(s_dv),    32'(e.dv));
      chk("acc_o sat",    32'(s_acc),   32'(e.acc_s));
      chk("acc_valid_o",  32'(s_accv),  32'(e.accv));
      chk("weight_o",     32'(s_wo),    32'(e.wo));
      chk("ovf_o sat",    32'(s_ovf),   32'(e.ovf));
      chk("mac_cnt_o",    32'(s_mac),   32'(e.mac));
      chk("skip_cnt_o",   32'(s_skip),  32'(e.skip));
      chk("acc_o wrap",   32'(w_acc),   32'(e.acc_w));
      chk("ovf_o wrap",   32'(w_ovf),   32'(e.ovf));
      chk("wrap data/v",  {23'd0, w_dv, w_accv, w_data}, {23'd0, e.dv, e.accv, e.data});
      chk("wrap w/cnt",   {16'd0, w_wo, w_mac, w_skip}, {16'd0, e.wo, 4'(e.mac), 4'(e.skip)});
      if (e.sp_on) begin
        chk("spec acc sat",  32'(s_acc),  32'(e.sp_acc));
        chk("spec acc wrap", 32'(w_acc),  32'(e.sp_accw));
        chk("spec accv",     32'(s_accv), 32'(e.sp_accv));
        chk("spec ovf",      32'(s_ovf),  32'(e.sp_ovf));
      end
      if (e.sp_cnt) begin
        chk("spec mac", 32'(s_mac),  32'(e.sp_mac));
        chk("spec skip", 32'(s_skip), 32'(e.sp_skip));
      end
    end
  end

  initial begin
    logic [7:0] d, w;
    logic [AW-1:0] a;
    // Reset with random inputs on every other pin.
    for (int i = 0; i < 3; i++) begin
      spec(0, 0, 0, 0); spec_cnt(0, 0);
      step(1, 1'($urandom), 8'($urandom), 1'($urandom), AW'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    // First MAC after reset sees w_act = 0 -> skip, pass-through.
    spec(10, 10, 1, 0); spec_cnt(0, 1);
    step(0, 1, 5, 1, 10, 0, 0, 0, 0);
    // Load 3, swap, then 5*3+10.
    step(0, 1, 0, 0, 0, 3, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    spec(25, 25, 1, 0); spec_cnt(1, 1);
    step(0, 1, 5, 1, 10, 0, 0, 0, 0);
    // Double buffer: load 7 while streaming 2*3; swap cycle still uses 3.
    spec(6, 6, 1, 0);   step(0, 1, 2, 1, 0, 7, 1, 0, 0);
    spec(6, 6, 1, 0);   step(0, 1, 2, 1, 0, 0, 0, 0, 0);
    spec(6, 6, 1, 0);   step(0, 1, 2, 1, 0, 0, 0, 1, 0);
    spec(14, 14, 1, 0); step(0, 1, 2, 1, 0, 0, 0, 0, 0);
    // Saturation vs wrap: 32760 + 10*10.
    step(0, 1, 0, 0, 0, 10, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    spec(32767, -32676, 1, 1); step(0, 1, 10, 1, 16'd32760, 0, 0, 0, 0);
    spec(15, 15, 1, 1);        step(0, 1, 1, 1, 5, 0, 0, 0, 0);
    spec(0, 0, 0, 0); spec_cnt(0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    // Zero skip with w = 1: data 0,2,0,4.
    step(0, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    spec(4, 4, 1, 0); spec_cnt(2, 2); step(0, 1, 4, 1, 0, 0, 0, 0, 0);
    spec(9, 9, 0, 0); spec_cnt(2, 2); step(0, 1, 7, 0, 9, 0, 0, 0, 0);
    // Stall for 5 cycles with random inputs: everything frozen.
    for (int i = 0; i < 5; i++) begin
      spec(9, 9, 0, 0); spec_cnt(2, 2);
      step(0, 0, 8'($urandom), 1'($urandom), AW'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    spec(3, 3, 1, 0); step(0, 1, 3, 1, 0, 0, 0, 0, 0);
    // Swap with empty shadow: w_act stays 1.
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    spec(3, 3, 1, 0); step(0, 1, 3, 1, 0, 0, 0, 0, 0);
    // Load 9, then load 4 + swap together: w_act = 9, shadow keeps 4 as full.
    step(0, 1, 0, 0, 0, 9, 1, 0, 0);
    step(0, 1, 0, 0, 0, 4, 1, 1, 0);
    spec(9, 9, 1, 0); step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    spec(4, 4, 1, 0); step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      w = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      case ($urandom_range(0, 2))
        0:       a = AW'($urandom);
        1:       a = 16'h7f00 | AW'($urandom_range(0, 255));
        default: a = 16'h8000 | AW'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), d,
           1'($urandom_range(0, 4) != 0), a, w,
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 39) == 0));
    end
    // Drain the scoreboard with a bounded wait.
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
